// File: rtl/apb_mailbox.sv
// apb_mailbox: APB completer fronting a TX FIFO (APB writes -> stream) and an RX FIFO
// (stream -> APB reads), plus STATUS/CONTROL and a level RX interrupt. Option: APB_MAILBOX_PROT_EN.
module apb_mailbox #(
  parameter int C_APB_ADDR_WIDTH = 12,
  parameter int C_APB_DATA_WIDTH = 32,
  parameter int LGFIFO           = 4
) (
  input  logic                          S_APB_PCLK,
  input  logic                          S_APB_PRESET,
  input  logic                          S_APB_PSEL,
  input  logic                          S_APB_PENABLE,
  output logic                          S_APB_PREADY,
  input  logic [C_APB_ADDR_WIDTH-1:0]   S_APB_PADDR,
  input  logic                          S_APB_PWRITE,
  input  logic [C_APB_DATA_WIDTH-1:0]   S_APB_PWDATA,
  input  logic [C_APB_DATA_WIDTH/8-1:0] S_APB_PWSTRB,
  input  logic [2:0]                    S_APB_PPROT,
  output logic [C_APB_DATA_WIDTH-1:0]   S_APB_PRDATA,
  output logic                          S_APB_PSLVERR,
  output logic                          M_TX_VALID,
  input  logic                          M_TX_READY,
  output logic [C_APB_DATA_WIDTH-1:0]   M_TX_DATA,
  input  logic                          S_RX_VALID,
  output logic                          S_RX_READY,
  input  logic [C_APB_DATA_WIDTH-1:0]   S_RX_DATA,
  output logic                          INT_RX
);
  localparam int DW    = C_APB_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 1 << LGFIFO;
  localparam int CW    = LGFIFO + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACK} state_t;
  state_t state, state_nx;

  logic          access, commit, err_q, err_nx, ctrl_wr, ctrl_denied;
  logic [1:0]    addr;
  logic [DW-1:0] rdata_q, rdata_nx, wdata_m, status;
  logic          irq_en, irq_en_nx, int_rx;

  logic [DW-1:0]     tx_mem [DEPTH];
  logic [LGFIFO-1:0] tx_wr, tx_rd;
  logic [CW-1:0]     tx_count, tx_count_nx;
  logic              tx_full, tx_empty, tx_push, tx_pop, tx_flush;

  logic [DW-1:0]     rx_mem [DEPTH];
  logic [LGFIFO-1:0] rx_wr, rx_rd;
  logic [CW-1:0]     rx_count, rx_count_nx;
  logic              rx_full, rx_empty, rx_push, rx_pop, rx_flush;

  logic unused;
  assign unused = &{1'b0, S_APB_PADDR, S_APB_PPROT};

`ifdef APB_MAILBOX_PROT_EN
  assign ctrl_denied = !S_APB_PPROT[0];
`else
  assign ctrl_denied = 1'b0;
`endif

  assign access = S_APB_PSEL && S_APB_PENABLE;
  assign addr   = S_APB_PADDR[3:2];

  // Setup is required before access so a transfer cut by reset is not resumed.
  always_ff @(posedge S_APB_PCLK) begin
    if (S_APB_PRESET) state <= ST_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (S_APB_PSEL && !S_APB_PENABLE) state_nx = ST_SETUP;
      ST_SETUP: if (access) state_nx = ST_ACK;
                else if (!S_APB_PSEL) state_nx = ST_IDLE;
      ST_ACK:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign S_APB_PREADY  = (state == ST_ACK);
  assign S_APB_PSLVERR = S_APB_PREADY && err_q;
  assign S_APB_PRDATA  = (S_APB_PREADY && !S_APB_PWRITE) ? rdata_q : '0;
  assign commit        = S_APB_PREADY && access && !err_q;

  assign status = DW'({int_rx, rx_empty, rx_full, tx_empty, tx_full,
                       8'(rx_count), 8'(tx_count)});

  // Response is decided in the first access cycle and held for the ready cycle.
  always_comb begin
    err_nx   = 1'b0;
    rdata_nx = '0;
    case (addr)
      2'd0: begin
        if (S_APB_PWRITE) err_nx = tx_full;
        else begin
          err_nx   = rx_empty;
          rdata_nx = rx_empty ? '0 : rx_mem[rx_rd];
        end
      end
      2'd1: begin
        if (S_APB_PWRITE) err_nx = 1'b1;
        else              rdata_nx = status;
      end
      2'd2: begin
        if (S_APB_PWRITE) err_nx = ctrl_denied;
        else              rdata_nx = DW'({irq_en, 2'b00});
      end
      default: err_nx = 1'b1;
    endcase
  end

  always_ff @(posedge S_APB_PCLK) begin
    if (S_APB_PRESET) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state == ST_SETUP && access) begin
      err_q   <= err_nx;
      rdata_q <= rdata_nx;
    end
  end

  always_comb begin
    wdata_m = '0;
    for (int b = 0; b < SW; b++)
      wdata_m[8*b +: 8] = S_APB_PWSTRB[b] ? S_APB_PWDATA[8*b +: 8] : 8'h00;
  end

  assign ctrl_wr   = commit && S_APB_PWRITE && addr == 2'd2 && S_APB_PWSTRB[0];
  assign tx_flush  = ctrl_wr && S_APB_PWDATA[0];
  assign rx_flush  = ctrl_wr && S_APB_PWDATA[1];
  assign irq_en_nx = ctrl_wr ? S_APB_PWDATA[2] : irq_en;

  assign tx_full    = (tx_count == CW'(DEPTH));
  assign tx_empty   = (tx_count == '0);
  assign rx_full    = (rx_count == CW'(DEPTH));
  assign rx_empty   = (rx_count == '0);
  assign M_TX_VALID = !tx_empty;
  assign M_TX_DATA  = tx_mem[tx_rd];
  assign S_RX_READY = !rx_full && !rx_flush;

  assign tx_push = commit && S_APB_PWRITE && addr == 2'd0;
  assign tx_pop  = !tx_empty && M_TX_READY;
  assign rx_push = S_RX_VALID && S_RX_READY;
  assign rx_pop  = commit && !S_APB_PWRITE && addr == 2'd0;

  // Flush wins over any same-cycle stream transfer.
  always_comb begin
    tx_count_nx = tx_count;
    if (tx_flush)                tx_count_nx = '0;
    else if (tx_push && !tx_pop) tx_count_nx = tx_count + CW'(1);
    else if (!tx_push && tx_pop) tx_count_nx = tx_count - CW'(1);
  end

  always_comb begin
    rx_count_nx = rx_count;
    if (rx_flush)                rx_count_nx = '0;
    else if (rx_push && !rx_pop) rx_count_nx = rx_count + CW'(1);
    else if (!rx_push && rx_pop) rx_count_nx = rx_count - CW'(1);
  end

  always_ff @(posedge S_APB_PCLK) begin
    if (S_APB_PRESET) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
      irq_en   <= 1'b0;
      int_rx   <= 1'b0;
    end else begin
      tx_count <= tx_count_nx;
      rx_count <= rx_count_nx;
      irq_en   <= irq_en_nx;
      int_rx   <= irq_en_nx && (rx_count_nx != '0);
      if (tx_push) tx_wr <= tx_wr + LGFIFO'(1);
      if (tx_flush)    tx_rd <= tx_wr;
      else if (tx_pop) tx_rd <= tx_rd + LGFIFO'(1);
      if (rx_push) rx_wr <= rx_wr + LGFIFO'(1);
      if (rx_flush)    rx_rd <= rx_wr;
      else if (rx_pop) rx_rd <= rx_rd + LGFIFO'(1);
    end
  end

  always_ff @(posedge S_APB_PCLK) begin
    if (tx_push) tx_mem[tx_wr] <= wdata_m;
    if (rx_push) rx_mem[rx_wr] <= S_RX_DATA;
  end

  assign INT_RX = int_rx;
endmodule
